// File: rtl/arb_rr_ctrl.sv
// -----------------------------------------------------------------------------
// arb_rr_ctrl
//
// Round-robin front end for NREQ local requesters that share one resource.
// The resource sits behind an upstream arbiter that uses a four-phase rc/gc
// handshake. When the block is idle it picks the next requester in round-robin
// order. It then raises rc_o and waits for gc_i. If the chosen requester is
// still requesting at that point, it receives a one-hot grant, which it keeps
// until it drops its request. The handshake always finishes with a release
// phase, in which the block waits for gc_i to return low.
//
// Ports
//   clk      : single clock, all state on the rising edge
//   rst_n    : asynchronous active-low reset
//   req_i    : per-requester level request (NREQ bits)
//   gnt_o    : per-requester grant, one-hot or zero (NREQ bits)
//   rc_o     : request to the shared-resource arbiter
//   gc_i     : grant from the shared-resource arbiter
//   owner_o  : index of the current or most recent owner (IDXW bits)
//   busy_o   : high in any state other than IDLE
//
// Build option
//   ARB_INPUT_SYNC_EN : when defined, req_i and gc_i each pass through a
//                       two-flop synchronizer before the FSM uses them. Every
//                       handshake latency grows by two cycles.
// -----------------------------------------------------------------------------
module arb_rr_ctrl #(
  parameter int NREQ = 4,
  parameter int IDXW = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req_i,
  output logic [NREQ-1:0] gnt_o,
  output logic            rc_o,
  input  logic            gc_i,
  output logic [IDXW-1:0] owner_o,
  output logic            busy_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RES_REQ = 2'd1,
    GRANT   = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

  state_t          state;
  logic [IDXW-1:0] ptr;      // last requester that actually received a grant
  logic            granted;  // a grant was issued in the current transaction

  // Versions of the inputs that the FSM is allowed to look at.
  logic [NREQ-1:0] req_s;
  logic            gc_s;

`ifdef ARB_INPUT_SYNC_EN
  logic [NREQ-1:0] req_meta;
  logic            gc_meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_meta <= '0;
      req_s    <= '0;
      gc_meta  <= 1'b0;
      gc_s     <= 1'b0;
    end else begin
      req_meta <= req_i;
      req_s    <= req_meta;
      gc_meta  <= gc_i;
      gc_s     <= gc_meta;
    end
  end
`else
  assign req_s = req_i;
  assign gc_s  = gc_i;
`endif

  // Round-robin pick. The search starts just above the last owner and wraps
  // around. ptr resets to NREQ-1, so requester 0 has highest priority after reset.
  logic            found;
  logic [IDXW-1:0] winner;

  always_comb begin
    // NOTE: every variable written here gets a default first; otherwise a path
    // that does not assign it would infer a latch.
    found  = 1'b0;
    winner = '0;
    for (int i = 1; i <= NREQ; i++) begin
      int idx;
      idx = (int'(ptr) + i) % NREQ;
      if (!found && req_s[IDXW'(idx)]) begin
        found  = 1'b1;
        winner = IDXW'(idx);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values from before the edge regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      gnt_o   <= '0;
      rc_o    <= 1'b0;
      busy_o  <= 1'b0;
      owner_o <= '0;
      ptr     <= IDXW'(NREQ - 1);
      granted <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // gc_i is deliberately ignored here; only requests start a transaction.
          if (found) begin
            owner_o <= winner;
            rc_o    <= 1'b1;
            busy_o  <= 1'b1;
            granted <= 1'b0;
            state   <= RES_REQ;
          end
        end
        RES_REQ: begin
          if (gc_s) begin
            if (req_s[owner_o]) begin
              gnt_o   <= ONE_HOT0 << owner_o;
              granted <= 1'b1;
              state   <= GRANT;
            end else begin
              // The owner gave up before the resource arrived. The resource
              // is handed straight back and no grant is issued.
              rc_o  <= 1'b0;
              state <= RELEASE;
            end
          end
        end
        GRANT: begin
          if (!req_s[owner_o]) begin
            gnt_o <= '0;
            rc_o  <= 1'b0;
            state <= RELEASE;
          end
        end
        RELEASE: begin
          if (!gc_s) begin
            // The pointer moves only when someone was actually served, so an
            // aborted requester keeps its place in the rotation.
            if (granted) ptr <= owner_o;
            busy_o <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arb_rr_ctrl.sv
// -----------------------------------------------------------------------------
// tb_arb_rr_ctrl
//
// Directed bench for arb_rr_ctrl in its default 4-requester configuration.
// Inputs change on the falling edge and outputs are read on the falling edge,
// so each value is read half a cycle after the rising edge that produced it.
// LAT is the number of rising edges from an input change to its effect at the
// outputs.
// -----------------------------------------------------------------------------
module tb_arb_rr_ctrl;

`ifdef ARB_INPUT_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  localparam int LEAVE   = 0;  // after release, leave the other requests alone
  localparam int RERAISE = 1;  // after release, the owner requests again
  localparam int CLEAR   = 2;  // when gc drops, withdraw every request

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req_i;
  logic [3:0] gnt_o;
  logic       rc_o;
  logic       gc_i;
  logic [1:0] owner_o;
  logic       busy_o;

  int checks = 0;
  int errors = 0;

  arb_rr_ctrl #(.NREQ(4), .IDXW(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_i   (req_i),
    .gnt_o   (gnt_o),
    .rc_o    (rc_o),
    .gc_i    (gc_i),
    .owner_o (owner_o),
    .busy_o  (busy_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete transaction for requester o. The caller has already driven
  // its request. The grant is held for 'hold' further cycles.
  task automatic serve(input int o, input int hold, input int after, input bit chk_lat);
    int n;
    n = 0;
    while (!rc_o && n < 16) begin @(negedge clk); n++; end
    check("rc_rise", 32'(rc_o), 32'd1);
    if (chk_lat) check("rc_latency", 32'(n), 32'(LAT));
    check("owner", 32'(owner_o), 32'(o));
    check("busy_in_txn", 32'(busy_o), 32'd1);
    check("no_early_gnt", 32'(gnt_o), 32'd0);

    gc_i = 1'b1;
    n = 0;
    while (gnt_o == 4'd0 && n < 16) begin @(negedge clk); n++; end
    check("gnt_latency", 32'(n), 32'(LAT));
    check("gnt_value", 32'(gnt_o), 32'(1 << o));
    check("rc_during_gnt", 32'(rc_o), 32'd1);
    repeat (hold) begin
      @(negedge clk);
      check("gnt_hold", 32'(gnt_o), 32'(1 << o));
    end

    req_i[o] = 1'b0;
    n = 0;
    while (gnt_o != 4'd0 && n < 16) begin @(negedge clk); n++; end
    check("drop_latency", 32'(n), 32'(LAT));
    check("rc_drop", 32'(rc_o), 32'd0);
    check("busy_release", 32'(busy_o), 32'd1);

    gc_i = 1'b0;
    if (after == CLEAR) req_i = 4'b0000;
    n = 0;
    while (busy_o && n < 16) begin @(negedge clk); n++; end
    check("idle_latency", 32'(n), 32'(LAT));
    check("gnt_idle", 32'(gnt_o), 32'd0);
    if (after == RERAISE) req_i[o] = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req_i = 4'b0000;
    gc_i  = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_gnt", 32'(gnt_o), 32'd0);
    check("rst_rc", 32'(rc_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_owner", 32'(owner_o), 32'd0);
    rst_n = 1'b1;

    // A stray gc_i while idle must not start anything.
    gc_i = 1'b1;
    repeat (LAT + 2) @(negedge clk);
    check("gc_idle_rc", 32'(rc_o), 32'd0);
    check("gc_idle_busy", 32'(busy_o), 32'd0);
    gc_i = 1'b0;
    repeat (LAT) @(negedge clk);

    // Single requester, full handshake.
    req_i = 4'b0001;
    serve(0, 1, CLEAR, 1'b1);

    // Fairness from reset: all four request continuously, order 0,1,2,3,0.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req_i = 4'b1111;
    serve(0, 2, RERAISE, 1'b1);
    serve(1, 2, RERAISE, 1'b0);
    serve(2, 2, RERAISE, 1'b0);
    serve(3, 2, RERAISE, 1'b0);
    serve(0, 2, CLEAR, 1'b0);

    // Late newcomer: requester 1 arrives while 2 owns the grant (ptr is now 0).
    req_i = 4'b0100;
    repeat (LAT) @(negedge clk);
    check("late_rc", 32'(rc_o), 32'd1);
    check("late_owner", 32'(owner_o), 32'd2);
    gc_i = 1'b1;
    repeat (LAT) @(negedge clk);
    check("late_gnt", 32'(gnt_o), 32'h4);
    req_i[1] = 1'b1;
    repeat (LAT + 1) @(negedge clk);
    check("late_gnt_kept", 32'(gnt_o), 32'h4);
    check("late_owner_kept", 32'(owner_o), 32'd2);
    req_i[2] = 1'b0;
    repeat (LAT) @(negedge clk);
    check("late_gnt_drop", 32'(gnt_o), 32'd0);
    check("late_rc_drop", 32'(rc_o), 32'd0);
    gc_i = 1'b0;
    repeat (LAT) @(negedge clk);
    check("late_idle", 32'(busy_o), 32'd0);
    serve(1, 1, CLEAR, 1'b0);

    // Move the pointer to 3 so that the abort test can show it stays put.
    req_i = 4'b1000;
    serve(3, 1, CLEAR, 1'b1);

    // Abort: requester 1 withdraws before gc_i arrives.
    req_i = 4'b0010;
    repeat (LAT) @(negedge clk);
    check("abort_rc", 32'(rc_o), 32'd1);
    check("abort_owner", 32'(owner_o), 32'd1);
    req_i = 4'b0000;
    repeat (LAT + 1) @(negedge clk);
    check("abort_rc_held", 32'(rc_o), 32'd1);
    check("abort_no_gnt", 32'(gnt_o), 32'd0);
    gc_i = 1'b1;
    repeat (LAT) @(negedge clk);
    check("abort_rc_fall", 32'(rc_o), 32'd0);
    check("abort_still_no_gnt", 32'(gnt_o), 32'd0);
    check("abort_busy", 32'(busy_o), 32'd1);
    gc_i = 1'b0;
    repeat (LAT) @(negedge clk);
    check("abort_idle", 32'(busy_o), 32'd0);
    // ptr is still 3, so requester 1 beats requester 2 (a moved ptr would pick 2).
    req_i = 4'b0110;
    serve(1, 1, CLEAR, 1'b1);

    // Reset in the middle of a grant.
    req_i = 4'b1000;
    repeat (LAT) @(negedge clk);
    check("mid_owner", 32'(owner_o), 32'd3);
    gc_i = 1'b1;
    repeat (LAT) @(negedge clk);
    check("mid_gnt", 32'(gnt_o), 32'h8);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_gnt", 32'(gnt_o), 32'd0);
    check("mid_rst_rc", 32'(rc_o), 32'd0);
    check("mid_rst_busy", 32'(busy_o), 32'd0);
    check("mid_rst_owner", 32'(owner_o), 32'd0);
    gc_i  = 1'b0;
    req_i = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    req_i = 4'b1001;
    serve(0, 1, CLEAR, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Backstop so that the run always ends, even if the DUT stalls.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/arb_rr_ctrl.md
ARB_RR_CTRL -- requirements
Module: arb_rr_ctrl

Interface
REQ-001 Parameter NREQ, default 4, number of requesters (2..8).
REQ-002 Parameter IDXW, default 2, owner index width; SHALL equal clog2(NREQ).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req_i  input  NREQ  per-requester four-phase request, level.
REQ-006 gnt_o  output  NREQ  per-requester grant, one-hot or zero.
REQ-007 rc_o  output  1  four-phase request to shared resource arbiter.
REQ-008 gc_i  input  1  four-phase grant from shared resource arbiter.
REQ-009 owner_o  output  IDXW  index of current or last owner.
REQ-010 busy_o  output  1  high in any state other than IDLE.

Function
REQ-011 FSM states SHALL be IDLE, RES_REQ, GRANT, RELEASE; all outputs registered.
REQ-012 IDLE: if any sampled req bit high, winner = first set bit searching from (ptr+1) mod NREQ upward with wrap; latch winner into owner_o, raise rc_o, go RES_REQ next cycle.
REQ-013 RES_REQ: hold rc_o high; on sampled gc_i high, if req of owner still high assert gnt_o[owner] next cycle and go GRANT.
REQ-014 RES_REQ abort: if req of owner sampled low when gc_i sampled high, no grant issued, go RELEASE; ptr unchanged.
REQ-015 GRANT: hold gnt_o[owner] and rc_o; on sampled req of owner low, drop gnt_o and rc_o in same cycle, go RELEASE.
REQ-016 RELEASE: hold rc_o low; on sampled gc_i low go IDLE; ptr <= owner only if a grant was issued this transaction.
REQ-017 Latency (sync disabled): req rise at edge k -> rc_o high after edge k; gc_i high at edge m -> gnt_o high after edge m; req fall at edge n -> gnt_o and rc_o low after edge n.
REQ-018 At most one gnt_o bit high at any time; gnt_o never high while rc_o low or outside GRANT.
REQ-019 Requests arriving or changing for non-owners during a transaction SHALL NOT affect current owner; evaluated only in IDLE.
REQ-020 Minimum one IDLE cycle between consecutive transactions; new winner re-evaluated there.
REQ-021 gc_i high while in IDLE or rising before rc_o SHALL be ignored; FSM waits in IDLE/RELEASE per protocol.
REQ-022 Round-robin: with all requesters continuously requesting, grants SHALL cycle 0,1,...,NREQ-1,0.

Reset
REQ-023 rst_n low SHALL immediately force state IDLE, gnt_o=0, rc_o=0, busy_o=0, owner_o=0, ptr=NREQ-1, synchronizer flops 0.
REQ-024 Reset mid-transaction drops grant and rc_o without completing handshake; after release, requester 0 has highest priority.
REQ-025 Reset deassertion SHALL be followed by normal operation from first clk edge with rst_n high.

Configuration
REQ-026 Macro ARB_INPUT_SYNC_EN defined: req_i and gc_i each pass through a two-flop synchronizer before FSM use; every latency in REQ-017 increases by exactly 2 cycles.
REQ-027 Macro ARB_INPUT_SYNC_EN undefined: req_i and gc_i used directly; inputs assumed synchronous to clk.

Verification
REQ-028 Single: reset, req_i=0001, gc_i returns 1 cycle after rc_o -> rc_o high at k+1, gnt_o=0001 one cycle after gc_i, release completes, busy_o=0.
REQ-029 Fairness: req_i=1111 held, each requester drops req 3 cycles after grant -> grant order 0,1,2,3,0; owner_o matches.
REQ-030 Late newcomer: req_i=0100 granted, req[1] rises during GRANT -> no change to gnt_o=0100; next transaction grants requester 1 (after wrap... pointer=2, search 3,0,1 -> 1).
REQ-031 Abort: req_i=0010 rises, drops before gc_i -> gnt_o stays 0, rc_o falls after gc_i high, ptr unchanged, next req 0010 served again.
REQ-032 Reset mid-GRANT: rst_n low while gnt_o=1000 -> gnt_o=0, rc_o=0 immediately; after reset req_i=1001 -> requester 0 granted.
REQ-033 Sync build: repeat REQ-028 with ARB_INPUT_SYNC_EN -> each latency +2 cycles, same grant sequence.
